// File: rtl/univ_regn_pkg.sv
// -----------------------------------------------------------------------------
// univ_regn_pkg
// Shared definitions for the universal register: the 3-bit mode encoding used
// by the top level, the next-state sub-module and any environment that wants
// to drive modes by name.
// Contents:
//   MODE_* localparams : operation select codes for the mode input
// -----------------------------------------------------------------------------
package univ_regn_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

endpackage

// File: rtl/univ_regn_next.sv
// -----------------------------------------------------------------------------
// univ_regn_next
// Purely combinational next-state logic for the universal register. Given the
// current contents and carry, it computes what q and carry become when the
// selected mode is applied. rst/pst/en priority is handled by the caller.
// Ports:
//   i_mode      : operation select (see univ_regn_pkg)
//   i_q         : current register contents, N bits
//   i_carry     : current carry flag
//   i_d         : parallel load data, N bits
//   i_sin_l     : serial input entering bit N-1 on shift right
//   i_sin_r     : serial input entering bit 0 on shift left
//   o_q_nxt     : next register contents, N bits
//   o_carry_nxt : next carry / borrow / shifted-out bit
// -----------------------------------------------------------------------------
module univ_regn_next
  import univ_regn_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [2:0]   i_mode,
  input  logic [N-1:0] i_q,
  input  logic         i_carry,
  input  logic [N-1:0] i_d,
  input  logic         i_sin_l,
  input  logic         i_sin_r,
  output logic [N-1:0] o_q_nxt,
  output logic         o_carry_nxt
);

  // One extra bit on the add/subtract: its top bit is the wrap indicator
  // (carry out of all-ones on INC, borrow out of zero on DEC).
  logic [N:0] w_inc;
  logic [N:0] w_dec;

  assign w_inc = {1'b0, i_q} + {{N{1'b0}}, 1'b1};
  assign w_dec = {1'b0, i_q} - {{N{1'b0}}, 1'b1};

  always_comb begin
    o_q_nxt     = i_q;
    o_carry_nxt = i_carry;
    case (i_mode)
      MODE_HOLD: begin
        o_q_nxt     = i_q;
        o_carry_nxt = i_carry;
      end
      MODE_LOAD: begin
        o_q_nxt     = i_d;
        o_carry_nxt = 1'b0;
      end
      MODE_SHL: begin
        o_q_nxt     = {i_q[N-2:0], i_sin_r};
        o_carry_nxt = i_q[N-1];
      end
      MODE_SHR: begin
        o_q_nxt     = {i_sin_l, i_q[N-1:1]};
        o_carry_nxt = i_q[0];
      end
      MODE_ROL: begin
        o_q_nxt     = {i_q[N-2:0], i_q[N-1]};
        o_carry_nxt = i_q[N-1];
      end
      MODE_ROR: begin
        o_q_nxt     = {i_q[0], i_q[N-1:1]};
        o_carry_nxt = i_q[0];
      end
      MODE_INC: begin
        o_q_nxt     = w_inc[N-1:0];
        o_carry_nxt = w_inc[N];
      end
      MODE_DEC: begin
        o_q_nxt     = w_dec[N-1:0];
        o_carry_nxt = w_dec[N];
      end
      default: begin
        o_q_nxt     = i_q;
        o_carry_nxt = i_carry;
      end
    endcase
  end

endmodule

// File: rtl/univ_regn.sv
// -----------------------------------------------------------------------------
// univ_regn
// N-bit universal register: hold, parallel load, shift left/right with serial
// inputs, rotate left/right, increment and decrement, with a registered
// carry/shift-out flag. Priority at each rising edge: rst > pst > en==0 > mode.
// Ports:
//   clk    : rising-edge clock for all state
//   rst    : synchronous active-high reset  (q <= RST_VAL, carry <= 0)
//   pst    : synchronous active-high preset (q <= PST_VAL, carry <= 0)
//   en     : clock enable for mode operations; 0 holds q and carry
//   mode   : operation select (univ_regn_pkg MODE_*)
//   d      : parallel load data
//   sin_r  : serial input into bit 0 on shift left
//   sin_l  : serial input into bit N-1 on shift right
//   q      : register contents
//   carry  : registered carry, borrow or shifted-out bit
//   sout_l : q[N-1], combinational
//   sout_r : q[0], combinational
//   zero   : (q == 0), combinational
// -----------------------------------------------------------------------------
module univ_regn
  import univ_regn_pkg::*;
#(
  parameter int           N       = 8,
  parameter logic [N-1:0] RST_VAL = {N{1'b0}},
  parameter logic [N-1:0] PST_VAL = {N{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pst,
  input  logic         en,
  input  logic [2:0]   mode,
  input  logic [N-1:0] d,
  input  logic         sin_r,
  input  logic         sin_l,
  output logic [N-1:0] q,
  output logic         carry,
  output logic         sout_l,
  output logic         sout_r,
  output logic         zero
);

  logic [N-1:0] r_q;
  logic         r_carry;
  logic [N-1:0] w_q_nxt;
  logic         w_carry_nxt;

  univ_regn_next #(
    .N (N)
  ) u_next (
    .i_mode      (mode),
    .i_q         (r_q),
    .i_carry     (r_carry),
    .i_d         (d),
    .i_sin_l     (sin_l),
    .i_sin_r     (sin_r),
    .o_q_nxt     (w_q_nxt),
    .o_carry_nxt (w_carry_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= RST_VAL;
      r_carry <= 1'b0;
    end else if (pst) begin
      r_q     <= PST_VAL;
      r_carry <= 1'b0;
    end else if (en) begin
      r_q     <= w_q_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  assign q      = r_q;
  assign carry  = r_carry;
  assign sout_l = r_q[N-1];
  assign sout_r = r_q[0];
  assign zero   = (r_q == {N{1'b0}});

endmodule

// File: doc/univ_regn.md
Name: univ_regn

Overview:
Parametrised N-bit universal register. It is the successor to the plain n-bit load register with reset, preset and enable. It adds a 3-bit mode select covering hold, parallel load, shift left/right with serial inputs, rotate left/right, increment and decrement, plus a registered carry/shift-out flag and a zero flag. It is a datapath building block for counters, serialisers and accumulator-style datapaths in the coursework designs.

Parameters:
- N, 8, register width in bits; legal range N >= 2.
- RST_VAL, {N{1'b0}}, value loaded into q on rst.
- PST_VAL, {N{1'b1}}, value loaded into q on pst.

Ports:
- clk, input, 1, rising-edge clock for all state.
- rst, input, 1, synchronous active-high reset.
- pst, input, 1, synchronous active-high preset.
- en, input, 1, clock enable for mode operations; 0 means hold.
- mode, input, 3, operation select (encoding under Behaviour).
- d, input, N, parallel load data.
- sin_r, input, 1, serial input shifted into bit 0 on shift left.
- sin_l, input, 1, serial input shifted into bit N-1 on shift right.
- q, output, N, register contents.
- carry, output, 1, registered carry, borrow or shifted-out bit.
- sout_l, output, 1, combinational q[N-1].
- sout_r, output, 1, combinational q[0].
- zero, output, 1, combinational (q == 0).

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst. All state updates on the rising clk edge only.
- State consists of q and carry. sout_l, sout_r and zero are combinational from q.
- Priority at each edge, highest first: rst > pst > en==0 > mode.
  - rst=1: q <= RST_VAL, carry <= 0. pst, en and mode are ignored.
  - pst=1 (rst=0): q <= PST_VAL, carry <= 0. en and mode are ignored.
  - en=0: q and carry hold, whatever the mode.
- Mode encoding (applies when en=1 and no rst/pst):
  - 000 HOLD: q and carry unchanged.
  - 001 LOAD: q <= d; carry <= 0.
  - 010 SHL: q <= {q[N-2:0], sin_r}; carry <= q[N-1].
  - 011 SHR: q <= {sin_l, q[N-1:1]}; carry <= q[0].
  - 100 ROL: q <= {q[N-2:0], q[N-1]}; carry <= q[N-1].
  - 101 ROR: q <= {q[0], q[N-1:1]}; carry <= q[0].
  - 110 INC: q <= q + 1, modulo 2^N; carry <= 1 iff q was all-ones (wrap to 0), else 0.
  - 111 DEC: q <= q - 1, modulo 2^N; carry <= 1 iff q was 0 (wrap to all-ones), else 0.
- Latency: one cycle from input sampling to the new q/carry. sout_l, sout_r and zero follow q with zero cycles of delay.
- Reset values: q = RST_VAL, carry = 0, sout_l = RST_VAL[N-1], sout_r = RST_VAL[0], zero = (RST_VAL == 0).
- After power-up, outputs are undefined until the first rst edge. The bench must assert rst on the first cycle.
- Reset mid-sequence: rst asserted during a run of INC/shift cycles takes effect on that edge. The next edge resumes the selected mode from RST_VAL.
- Arithmetic is unsigned. No sign extension. Widths are exact N bits with no internal widening beyond the carry detect.
- No X propagation from sin_l/sin_r when the mode does not use them.

Decomposition:
- Shared package univ_regn_pkg holds the mode localparams: MODE_HOLD=3'b000, MODE_LOAD=3'b001, MODE_SHL=3'b010, MODE_SHR=3'b011, MODE_ROL=3'b100, MODE_ROR=3'b101, MODE_INC=3'b110, MODE_DEC=3'b111.
- One sub-module is natural: univ_regn_next.
  - Purely combinational, parametrised by N.
  - Inputs: mode, q, carry, d, sin_l, sin_r.
  - Outputs: {carry_nxt, q_nxt}.
- The top level holds the state flops and applies the rst/pst/en priority. Sharing the package lets the bench drive modes by name.

Test Plan:
- Reset and preset: rst=1 for 1 edge gives q=0x00, carry=0, zero=1. Then pst=1 with en=0 gives q=0xFF, carry=0, zero=0. Then rst=1 and pst=1 together gives q=0x00, confirming rst wins.
- Load and hold: LOAD d=0xA5 gives q=0xA5. Then en=0 with mode=INC for 3 edges keeps q=0xA5. Then HOLD with en=1 keeps q=0xA5, carry=0.
- Shifts: from q=0x81, SHL sin_r=1 gives q=0x03, carry=1. SHR sin_l=0 gives q=0x01, carry=1. SHR sin_l=1 gives q=0x80, carry=1; check sout_l=1, sout_r=0.
- Rotates: from q=0x81, ROL gives q=0x03, carry=1. ROR gives q=0x81, carry=1. Eight consecutive ROR edges return q=0x81.
- Counter wrap: LOAD 0xFE, then INC gives q=0xFF, carry=0. INC gives q=0x00, carry=1, zero=1. DEC gives q=0xFF, carry=1. DEC gives q=0xFE, carry=0.
- Reset mid-count: INC from 0x10 for 3 edges gives q=0x13. Then rst for 1 edge gives q=0x00. Then INC resumes, q=0x01. Repeat the whole plan with N=4 and PST_VAL=4'hA for parameter coverage.
